keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
- Parametrised successor to the 4x3 keypad / 6-digit shift-entry front end.
- Scans an N_ROWS x N_COLS matrix keypad and debounces on whole-scan frames, emitting exactly one event per physical press.
- Maintains a right-entry digit buffer with CLEAR, BACKSPACE and a configurable overflow policy; multiplexes one BCD code per digit slot to the shared seg7 decoder.
- Sits between the pin-level keypad/digit-select and bcd_to_seg7; runs on the system clock with a tick enable, so no derived clocks are needed.

Parameters:
- N_DIGITS, 6, number of display digits / buffer slots (2..8).
- N_ROWS, 4, keypad rows driven by row_sel (2..4).
- N_COLS, 3, keypad columns sampled on col_n (2..4).
- DEB_FRAMES, 3, consecutive identical scan frames required to accept a press or a release (1..15).
- OVF_MODE, 0, 0 = shift out oldest digit when full; 1 = reject new digit when full.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick  in  1  scan-step enable, one-cycle pulse; all state except outputs held between ticks.
- col_n  in  N_COLS  keypad columns, active-low, bit c = column c.
- row_sel  out  clog2(N_ROWS)  row currently driven.
- dig_sel  out  clog2(N_DIGITS)  digit slot currently displayed; 0 = leftmost.
- seg_code  out  4  BCD of displayed slot; 4'hF = blank.
- key_valid  out  1  one-clk pulse per accepted key event.
- key_code  out  4  code of last accepted key; held between events.
- digit_count  out  clog2(N_DIGITS+1)  number of digits entered.
- full  out  1  digit_count == N_DIGITS.

Behaviour:
- Reset values:
  - row_sel = 0, dig_sel = 0, seg_code = 4'hF, key_valid = 0, key_code = 4'hF, digit_count = 0, full = 0.
  - All buffer slots = 4'hF; debounce counters 0; FSM in IDLE.
- Scan:
  - On each tick, row_sel advances 0..N_ROWS-1 and wraps.
  - col_n is sampled in the same tick, before row_sel advances.
  - A frame is one full row pass. The frame result is NONE, a single key index r*N_COLS+c, or MULTI (more than one key closed in the frame).
- dig_sel advances on each tick, 0..N_DIGITS-1, wraps, and is independent of row_sel. seg_code is registered: buffer slot dig_sel, one clk after dig_sel changes.
- Key map (package constants):
  - indices 0..8 -> digits 1..9.
  - index 9 -> CLEAR (4'hA).
  - index 10 -> digit 0.
  - index 11 -> BACKSPACE (4'hB).
  - Any other index is ignored.
- Debounce FSM: IDLE -> CANDIDATE -> HELD -> RELEASE -> IDLE.
  - IDLE: a frame result of a single key latches that index and enters CANDIDATE with cnt = 1.
  - CANDIDATE:
    - Same index -> cnt++.
    - Different index, NONE or MULTI -> back to IDLE.
    - When cnt reaches DEB_FRAMES, go to HELD and fire the event: key_valid pulses one clk at the frame boundary, and key_code updates in the same cycle.
  - HELD: any non-NONE frame stays in HELD (auto-repeat is not supported); a NONE frame enters RELEASE with cnt = 1.
  - RELEASE: DEB_FRAMES consecutive NONE frames -> IDLE; any non-NONE frame -> back to HELD.
  - MULTI is never accepted as a key.
- Buffer actions, applied in the key_valid cycle:
  - Digit, not full: shift left, new digit into the rightmost slot, count++.
  - Digit, full, OVF_MODE = 0: shift left, oldest digit is lost, count unchanged.
  - Digit, full, OVF_MODE = 1: buffer unchanged; key_valid still pulses.
  - BACKSPACE: shift right, 4'hF into the leftmost slot, count-- (saturates at 0). An empty buffer is unchanged.
  - CLEAR: all slots = 4'hF, count = 0.
- full is combinational from digit_count.
- Reset mid-press: the FSM returns to IDLE. A key still held after reset must pass the full CANDIDATE sequence again.
- tick held high continuously is legal and advances every clk.

Decomposition:
- Package keypad_pkg holds:
  - Key index constants: KEY_CLEAR = 9, KEY_ZERO = 10, KEY_BSP = 11.
  - Codes BLANK = 4'hF, CODE_CLEAR = 4'hA, CODE_BSP = 4'hB.
  - The debounce FSM state enum.
- One sub-module: keypad_frame_scan (row counter, column sampling, frame result and index). The debounce FSM and buffer stay in the top.

Test Plan:
- Reset, then 20 ticks with no keys -> seg_code 4'hF on every slot; digit_count 0; key_valid never asserts.
- Press key index 4 for 5 frames (DEB_FRAMES = 3), then release -> exactly one key_valid, key_code 5, rightmost slot 5, count 1.
- Enter 1,2,3,4,5,6,7 with OVF_MODE = 0 -> slots left-to-right 2,3,4,5,6,7, full = 1. Repeat with OVF_MODE = 1 -> slots 1..6, seventh key pulses key_valid only.
- Enter 9,8, then BACKSPACE -> slots F,F,F,F,F,9, count 1. Then CLEAR -> all F, count 0. BACKSPACE on the empty buffer -> no change.
- Bounce: key 2 alternating closed/open every frame for 6 frames, then stable -> no event until 3 stable frames; then exactly one event. Two keys in the same frame -> no event.
- Assert rst during HELD with the key still closed -> outputs at reset values; one new event after DEB_FRAMES frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, enums and key map
// for the keypad entry front end.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd9;
  localparam logic [3:0] KEY_ZERO  = 4'd10;
  localparam logic [3:0] KEY_BSP   = 4'd11;

  localparam logic [3:0] BLANK      = 4'hF;
  localparam logic [3:0] CODE_CLEAR = 4'hA;
  localparam logic [3:0] CODE_BSP   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAND,
    S_HELD,
    S_REL
  } deb_state_t;

  typedef enum logic [1:0] {
    F_NONE,
    F_SINGLE,
    F_MULTI
  } frame_kind_t;

  // Key index to code; unmapped indices give BLANK.
  function automatic logic [3:0] key_map(
    input logic [3:0] idx
  );
    logic [3:0] code;
    code = BLANK;
    if (idx <= 4'd8)
      code = idx + 4'd1;
    else if (idx == KEY_CLEAR)
      code = CODE_CLEAR;
    else if (idx == KEY_ZERO)
      code = 4'd0;
    else if (idx == KEY_BSP)
      code = CODE_BSP;
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_scan.sv
// keypad_frame_scan: row stepping and column sampling,
// folding one full row pass into a frame result.
module keypad_frame_scan
  import keypad_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 3,
  localparam int RW = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_COLS-1:0] col_n,
  output logic [RW-1:0]     row_sel,
  output logic              frame_done,
  output frame_kind_t       frame_kind,
  output logic [3:0]        frame_idx
);

  logic [1:0] acc_n;
  logic [3:0] acc_idx;
  logic [1:0] row_n;
  logic [3:0] row_idx;
  logic [1:0] tot_n;
  logic [2:0] sum_n;
  logic       last_row;

  // Merge this row's closures into the running frame tally.
  always_comb begin
    row_n   = '0;
    row_idx = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (!col_n[c]) begin
        if (row_n == 2'd0)
          row_idx = 4'(int'(row_sel) * N_COLS + c);
        if (row_n != 2'd2)
          row_n = row_n + 2'd1;
      end
    end
    sum_n = {1'b0, acc_n} + {1'b0, row_n};
    tot_n = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    last_row = (row_sel == RW'(N_ROWS - 1));
    frame_done = tick && last_row;
    frame_idx = (acc_n != 2'd0) ? acc_idx : row_idx;
    case (tot_n)
      2'd0:    frame_kind = F_NONE;
      2'd1:    frame_kind = F_SINGLE;
      default: frame_kind = F_MULTI;
    endcase
  end

  // Row counter and per-frame accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sel <= '0;
      acc_n   <= '0;
      acc_idx <= '0;
    end else if (tick) begin
      if (last_row) begin
        row_sel <= '0;
        acc_n   <= '0;
        acc_idx <= '0;
      end else begin
        row_sel <= row_sel + RW'(1);
        acc_n   <= tot_n;
        acc_idx <= frame_idx;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: frame debounce, digit entry
// buffer and display slot multiplexing.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 3,
  parameter int DEB_FRAMES = 3,
  parameter int OVF_MODE   = 0,
  localparam int RW = $clog2(N_ROWS),
  localparam int DW = $clog2(N_DIGITS),
  localparam int CW = $clog2(N_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_COLS-1:0] col_n,
  output logic [RW-1:0]     row_sel,
  output logic [DW-1:0]     dig_sel,
  output logic [3:0]        seg_code,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic [CW-1:0]     digit_count,
  output logic              full
);

  localparam logic [3:0] DEB = 4'(DEB_FRAMES);

  logic        frame_done;
  frame_kind_t frame_kind;
  logic [3:0]  frame_idx;

  deb_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] cand, cand_n;
  logic       accept;
  logic [3:0] new_code;
  logic       fire;
  logic [3:0] slots [N_DIGITS];

  keypad_frame_scan #(
    .N_ROWS(N_ROWS),
    .N_COLS(N_COLS)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .col_n     (col_n),
    .row_sel   (row_sel),
    .frame_done(frame_done),
    .frame_kind(frame_kind),
    .frame_idx (frame_idx)
  );

  assign full = (digit_count == CW'(N_DIGITS));

  // Debounce next state, evaluated once per frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_done) begin
      unique case (state)
        S_IDLE: begin
          if (frame_kind == F_SINGLE) begin
            cand_n = frame_idx;
            cnt_n  = 4'd1;
            if (DEB == 4'd1) begin
              state_n = S_HELD;
              accept  = 1'b1;
            end else begin
              state_n = S_CAND;
            end
          end
        end
        S_CAND: begin
          if (frame_kind == F_SINGLE &&
              frame_idx == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DEB) begin
              state_n = S_HELD;
              accept  = 1'b1;
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_kind == F_NONE) begin
            cnt_n   = 4'd1;
            state_n = (DEB == 4'd1) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (frame_kind == F_NONE) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DEB)
              state_n = S_IDLE;
          end else begin
            state_n = S_HELD;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    new_code = key_map(cand_n);
    fire     = accept && (new_code != BLANK);
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // Key event pulse and held key code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= BLANK;
    end else begin
      key_valid <= fire;
      if (fire)
        key_code <= new_code;
    end
  end

  // Right-entry digit buffer; slot 0 is leftmost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++)
        slots[i] <= BLANK;
      digit_count <= '0;
    end else if (fire) begin
      unique case (1'b1)
        (new_code <= 4'd9): begin
          if (!full || OVF_MODE == 0) begin
            for (int i = 0; i < N_DIGITS - 1; i++)
              slots[i] <= slots[i+1];
            slots[N_DIGITS-1] <= new_code;
          end
          if (!full)
            digit_count <= digit_count + CW'(1);
        end
        (new_code == CODE_CLEAR): begin
          for (int i = 0; i < N_DIGITS; i++)
            slots[i] <= BLANK;
          digit_count <= '0;
        end
        (new_code == CODE_BSP): begin
          if (digit_count != '0) begin
            slots[0] <= BLANK;
            for (int i = 1; i < N_DIGITS; i++)
              slots[i] <= slots[i-1];
            digit_count <= digit_count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Display slot stepping and registered BCD out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sel  <= '0;
      seg_code <= BLANK;
    end else begin
      seg_code <= slots[dig_sel];
      if (tick) begin
        if (dig_sel == DW'(N_DIGITS - 1))
          dig_sel <= '0;
        else
          dig_sel <= dig_sel + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard bench for both
// overflow policies against a frame-level model.
module tb_keypad_entry_ctrl;

  localparam int ND  = 6;
  localparam int NR  = 4;
  localparam int NC  = 3;
  localparam int DEB = 3;
  localparam int NK  = NR * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [NC-1:0] col_n0, col_n1;
  logic [1:0]    row0, row1;
  logic [2:0]    dsel0, dsel1;
  logic [3:0]    seg0, seg1;
  logic          kv0, kv1;
  logic [3:0]    kc0, kc1;
  logic [2:0]    dc0, dc1;
  logic          full0, full1;

  logic [15:0] pressed, next_pressed;

  keypad_entry_ctrl #(
    .N_DIGITS(ND), .N_ROWS(NR), .N_COLS(NC),
    .DEB_FRAMES(DEB), .OVF_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick),
    .col_n(col_n0), .row_sel(row0),
    .dig_sel(dsel0), .seg_code(seg0),
    .key_valid(kv0), .key_code(kc0),
    .digit_count(dc0), .full(full0)
  );

  keypad_entry_ctrl #(
    .N_DIGITS(ND), .N_ROWS(NR), .N_COLS(NC),
    .DEB_FRAMES(DEB), .OVF_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick),
    .col_n(col_n1), .row_sel(row1),
    .dig_sel(dsel1), .seg_code(seg1),
    .key_valid(kv1), .key_code(kc1),
    .digit_count(dc1), .full(full1)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its column low
  // while its row is driven.
  always_comb begin
    col_n0 = '1;
    col_n1 = '1;
    for (int c = 0; c < NC; c++) begin
      col_n0[c] = ~pressed[int'(row0) * NC + c];
      col_n1[c] = ~pressed[int'(row1) * NC + c];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model state.
  logic [3:0] dq0[$];
  logic [3:0] dq1[$];
  bit armed;
  int run_key, run_len, none_len;
  int tick_cnt;

  typedef struct {
    logic [3:0] code;
    int c0;
    int c1;
  } exp_t;
  exp_t expq[$];

  function automatic logic [3:0] map_code(input int idx);
    if (idx >= 0 && idx <= 8) return 4'(idx + 1);
    if (idx == 9)  return 4'hA;
    if (idx == 10) return 4'h0;
    if (idx == 11) return 4'hB;
    return 4'hF;
  endfunction

  task automatic model_key(input logic [3:0] code);
    if (code <= 4'd9) begin
      if (dq0.size() < ND) dq0.push_back(code);
      else begin
        void'(dq0.pop_front());
        dq0.push_back(code);
      end
      if (dq1.size() < ND) dq1.push_back(code);
    end else if (code == 4'hA) begin
      dq0.delete();
      dq1.delete();
    end else if (code == 4'hB) begin
      if (dq0.size() > 0) void'(dq0.pop_back());
      if (dq1.size() > 0) void'(dq1.pop_back());
    end
  endtask

  // One completed frame: a press counts once it has
  // been seen DEB frames in a row while the pad was
  // released long enough beforehand.
  task automatic model_frame();
    int n, idx;
    logic [3:0] code;
    exp_t e;
    n = 0;
    idx = 0;
    for (int k = NK - 1; k >= 0; k--)
      if (pressed[k]) begin
        n++;
        idx = k;
      end
    if (n == 0) begin
      run_len = 0;
      none_len++;
      if (!armed && none_len >= DEB) armed = 1;
    end else if (n > 1) begin
      run_len = 0;
      none_len = 0;
    end else begin
      none_len = 0;
      if (run_len > 0 && run_key != idx) run_len = 0;
      else run_len++;
      run_key = idx;
      if (armed && run_len == DEB) begin
        armed = 0;
        code = map_code(idx);
        if (code != 4'hF) begin
          model_key(code);
          e.code = code;
          e.c0 = dq0.size();
          e.c1 = dq1.size();
          expq.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    pressed = next_pressed;
    tick = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    if (tick) begin
      tick_cnt++;
      if (tick_cnt % NR == 0) model_frame();
    end
  endtask

  task automatic frames(input logic [15:0] mask,
                        input int n);
    int target;
    next_pressed = mask;
    target = tick_cnt + n * NR;
    while (tick_cnt < target) step();
  endtask

  task automatic press(input int idx, input int n);
    frames(16'(1) << idx, n);
    frames('0, DEB + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0;
    rst = 1'b1;
    dq0.delete();
    dq1.delete();
    expq.delete();
    armed = 1;
    run_len = 0;
    run_key = -1;
    none_len = 0;
    tick_cnt = 0;
    #1;
    check("rst_row0", row0, 0);
    check("rst_dsel0", dsel0, 0);
    check("rst_seg0", seg0, 4'hF);
    check("rst_kv0", kv0, 0);
    check("rst_kc0", kc0, 4'hF);
    check("rst_cnt0", dc0, 0);
    check("rst_full0", full0, 0);
    check("rst_row1", row1, 0);
    check("rst_dsel1", dsel1, 0);
    check("rst_seg1", seg1, 4'hF);
    check("rst_kv1", kv1, 0);
    check("rst_kc1", kc1, 4'hF);
    check("rst_cnt1", dc1, 0);
    check("rst_full1", full1, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reconstruct what each display slot last showed.
  logic [3:0] sh0 [ND];
  logic [3:0] sh1 [ND];
  int pd0 = 0, pd1 = 0;

  always @(negedge clk) begin
    if (pd0 < ND) sh0[pd0] <= seg0;
    if (pd1 < ND) sh1[pd1] <= seg1;
    pd0 <= int'(dsel0);
    pd1 <= int'(dsel1);
  end

  // Scoreboard monitor: pop one expectation per pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (kv0 || kv1)) begin
      if (expq.size() == 0) begin
        check("spurious_key_valid", {kv0, kv1}, 0);
      end else begin
        e = expq.pop_front();
        check("kv0", kv0, 1);
        check("kv1", kv1, 1);
        check("key_code0", kc0, e.code);
        check("key_code1", kc1, e.code);
        check("evt_count0", dc0, e.c0);
        check("evt_count1", dc1, e.c1);
        check("evt_full0", full0, e.c0 == ND);
        check("evt_full1", full1, e.c1 == ND);
      end
    end
  end

  task automatic check_display();
    logic [4*ND-1:0] e0, e1, a0, a1;
    int s0, s1;
    frames('0, 2);
    s0 = dq0.size();
    s1 = dq1.size();
    for (int i = 0; i < ND; i++) begin
      e0[4*(ND-1-i) +: 4] =
        (i < ND - s0) ? 4'hF : dq0[i - (ND - s0)];
      e1[4*(ND-1-i) +: 4] =
        (i < ND - s1) ? 4'hF : dq1[i - (ND - s1)];
      a0[4*(ND-1-i) +: 4] = sh0[i];
      a1[4*(ND-1-i) +: 4] = sh1[i];
    end
    check("display0", a0, e0);
    check("display1", a1, e1);
    check("count0", dc0, s0);
    check("count1", dc1, s1);
    check("full0", full0, s0 == ND);
    check("full1", full1, s1 == ND);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m;
    int r;
    rst = 1'b1;
    tick = 1'b0;
    pressed = '0;
    next_pressed = '0;
    tick_cnt = 0;
    do_reset();

    frames('0, 5);
    check_display();

    press(4, 5);
    check_display();

    press(9, 3);
    for (int i = 0; i < 7; i++) press(i, 3);
    check_display();

    press(9, 3);
    press(8, 3);
    press(7, 3);
    press(11, 3);
    check_display();
    press(9, 3);
    check_display();
    press(11, 3);
    check_display();

    for (int k = 0; k < 6; k++)
      frames((k % 2 == 0) ? 16'h0002 : 16'h0000, 1);
    frames(16'h0002, 4);
    frames('0, DEB + 1);
    check_display();

    frames(16'h0024, 4);
    frames('0, DEB + 1);
    frames(16'h0008, 2);
    frames(16'h0040, 4);
    frames('0, DEB + 1);
    check_display();

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      m = '0;
      if (r >= 3)
        m[$urandom_range(0, NK - 1)] = 1'b1;
      if (r >= 8)
        m[$urandom_range(0, NK - 1)] = 1'b1;
      frames(m, $urandom_range(1, 5));
    end
    frames('0, DEB + 1);
    check_display();

    frames(16'h0010, 4);
    do_reset();
    frames(16'h0010, 4);
    frames('0, DEB + 1);
    check_display();

    check("pending_events", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
